// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   localparam int unsigned WS_CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } stateT;

   typedef enum logic [1:0] {
      OP_RD,
      OP_WR,
      OP_BAD
   } opT;

   // Classify a strobe pair; both strobes at once is an illegal request
   function automatic opT decodeOp(input logic rd, input logic wr);
      if (rd && wr) begin
         return OP_BAD;
      end else if (wr) begin
         return OP_WR;
      end
      return OP_RD;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered, holding read port.
module dmem_array #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           we,
   input  logic                           re,
   input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
   input  logic [DATA_W-1:0]              din,
   output logic [DATA_W-1:0]              dout
);

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   // Array contents survive reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= din;
      end
   end

   // Read register only updates on a read, so it doubles as the held load data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= '0;
      end else if (re) begin
         dout <= mem[idx];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: accepts one request, waits WAIT_STATES cycles, then
// pulses ready with either the access result or err.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              busy,
   output logic              err
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   stateT               state;
   stateT               nextState;
   opT                  opQ;
   opT                  curOp;
   logic [ADDR_W-1:0]   addrQ;
   logic [ADDR_W-1:0]   curAddr;
   logic [DATA_W-1:0]   wdataQ;
   logic [WS_CNT_W-1:0] waitCnt;
   logic [WS_CNT_W-1:0] nextCnt;
   logic                accept;
   logic                fault;
   logic                ramWe;
   logic                ramRe;
   logic [IDX_W-1:0]    ramIdx;

   // Request under evaluation: live inputs while idle, latched copy afterwards
   always_comb begin
      curOp   = opQ;
      curAddr = addrQ;
      if (state == S_IDLE) begin
         curOp   = decodeOp(MemRead, MemWrite);
         curAddr = addr;
      end
   end

   assign accept = (state == S_IDLE) && (MemRead || MemWrite);

   // Upper-bit range check stops high addresses aliasing onto low words
   assign fault = (curOp == OP_BAD)
                || (curAddr[1:0] != 2'b00)
                || (curAddr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS));

   // Next-state and wait-counter logic
   always_comb begin
      nextState = state;
      nextCnt   = waitCnt;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               if (WAIT_STATES == 0) begin
                  nextState = S_RESP;
               end else begin
                  nextState = S_WAIT;
                  nextCnt   = WS_CNT_W'(WAIT_STATES - 1);
               end
            end
         end
         S_WAIT: begin
            if (waitCnt == '0) begin
               nextState = S_RESP;
            end else begin
               nextCnt = waitCnt - WS_CNT_W'(1);
            end
         end
         S_RESP:  nextState = S_IDLE;
         default: nextState = S_IDLE;
      endcase
   end

   // Read lands in the RAM register on the edge entering RESP; write commits leaving it
   assign ramWe  = (state == S_RESP) && (opQ == OP_WR) && !fault;
   assign ramRe  = (nextState == S_RESP) && (curOp == OP_RD) && !fault;
   assign ramIdx = curAddr[IDX_W+1:2];

   // State register, request latch and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         waitCnt <= '0;
         opQ     <= OP_RD;
         addrQ   <= '0;
         wdataQ  <= '0;
         ready   <= 1'b0;
         busy    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= nextState;
         waitCnt <= nextCnt;
         if (accept) begin
            opQ    <= curOp;
            addrQ  <= addr;
            wdataQ <= wdata;
         end
         ready <= (nextState == S_RESP);
         busy  <= (nextState != S_IDLE);
         err   <= (nextState == S_RESP) && fault;
      end
   end

   dmem_array #(
      .DATA_W      (DATA_W),
      .DEPTH_WORDS (DEPTH_WORDS)
   ) uArray (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (ramWe),
      .re    (ramRe),
      .idx   (ramIdx),
      .din   (wdataQ),
      .dout  (rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 2 and 3 wait states) checked
// against a word-array reference model.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 256;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [2:0]       memRead;
   logic [2:0]       memWrite;
   logic [2:0][31:0] addr;
   logic [2:0][31:0] wdata;
   logic [2:0][31:0] rdata;
   logic [2:0]       ready;
   logic [2:0]       busy;
   logic [2:0]       err;

   int unsigned wsOf [3] = '{0, 2, 3};

   logic [31:0] model  [3][DEPTH];
   logic [31:0] lastRd [3];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .MemRead(memRead[0]), .MemWrite(memWrite[0]),
      .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]),
      .busy(busy[0]), .err(err[0]));

   dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .WAIT_STATES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .MemRead(memRead[1]), .MemWrite(memWrite[1]),
      .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]),
      .busy(busy[1]), .err(err[1]));

   dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .WAIT_STATES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .MemRead(memRead[2]), .MemWrite(memWrite[2]),
      .addr(addr[2]), .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2]),
      .busy(busy[2]), .err(err[2]));

   // Reference model: apply one access by the fault rules, return expected rdata/err
   function automatic void modelAccess(input int d, input bit rd, input bit wr,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       output logic [31:0] expRd, output bit expErr);
      expErr = (rd && wr) || (a % 4 != 0) || (a / 4 >= DEPTH);
      if (!expErr) begin
         if (wr) model[d][a / 4] = wd;
         else    lastRd[d] = model[d][a / 4];
      end
      expRd = lastRd[d];
   endfunction

   // Drive one request, scramble inputs while it is in flight, collect the response
   task automatic access(input int d, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] gotRd, output bit gotErr,
                         output int lat, output bit protoOk);
      protoOk = 1'b1;
      lat     = 0;
      @(negedge clk);
      memRead[d] = rd; memWrite[d] = wr; addr[d] = a; wdata[d] = wd;
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (ready[d] === 1'b1) break;
         if (busy[d] !== 1'b1 || err[d] !== 1'b0) protoOk = 1'b0;
         lat++;
         if (lat > 20) break;
         memRead[d]  = 1'($urandom);
         memWrite[d] = 1'($urandom);
         addr[d]     = $urandom;
         wdata[d]    = $urandom;
      end
      gotRd  = rdata[d];
      gotErr = err[d];
      if (busy[d] !== 1'b1) protoOk = 1'b0;
      memRead[d] = 1'b0; memWrite[d] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (ready[d] !== 1'b0 || busy[d] !== 1'b0 || err[d] !== 1'b0) protoOk = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      memRead = '0; memWrite = '0; addr = '0; wdata = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({rdata[d], ready[d], busy[d], err[d]} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs dut%0d: rdata=%h ready=%b busy=%b err=%b, required all 0",
                     d, rdata[d], ready[d], busy[d], err[d]);
         end
         lastRd[d] = '0;
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_preload;
      logic [31:0] gRd, eRd;
      bit gErr, eErr, ok;
      int lat, bad;
      for (int d = 0; d < 3; d++) begin
         bad = 0;
         for (int w = 0; w < int'(DEPTH); w++) begin
            modelAccess(d, 1'b0, 1'b1, 32'(w * 4), $urandom, eRd, eErr);
            access(d, 1'b0, 1'b1, 32'(w * 4), model[d][w], gRd, gErr, lat, ok);
            if (gErr !== eErr || lat != int'(wsOf[d]) || !ok) bad++;
         end
         checks++;
         if (bad != 0) begin
            failures++;
            $display("FAIL preload dut%0d: %0d bad stores, required 0", d, bad);
         end
      end
   endtask

   task automatic test_store_load;
      logic [31:0] gRd, eRd;
      bit gErr, eErr, ok;
      int lat;
      modelAccess(1, 1'b0, 1'b1, 32'h10, 32'hCAFEBABE, eRd, eErr);
      access(1, 1'b0, 1'b1, 32'h10, 32'hCAFEBABE, gRd, gErr, lat, ok);
      checks++;
      if (lat != 2 || gErr !== 1'b0 || !ok) begin
         failures++;
         $display("FAIL store_latency: lat=%0d err=%b proto=%b, required lat=2 err=0 proto=1", lat, gErr, ok);
      end
      modelAccess(1, 1'b1, 1'b0, 32'h10, 32'h0, eRd, eErr);
      access(1, 1'b1, 1'b0, 32'h10, 32'h0, gRd, gErr, lat, ok);
      checks++;
      if (gRd !== 32'hCAFEBABE || gErr !== 1'b0 || lat != 2 || !ok) begin
         failures++;
         $display("FAIL load_after_store: rdata=%h err=%b lat=%0d, required rdata=cafebabe err=0 lat=2", gRd, gErr, lat);
      end
   endtask

   task automatic test_faults;
      logic [31:0] gRd, eRd;
      bit gErr, eErr, ok;
      int lat;
      logic [31:0] a [6] = '{32'h13, 32'h13, 32'h10, 32'h400, 32'h3FC, 32'h0};
      bit          r [6] = '{1, 0, 1, 1, 1, 1};
      bit          w [6] = '{0, 1, 0, 0, 0, 1};
      for (int i = 0; i < 6; i++) begin
         modelAccess(1, r[i], w[i], a[i], 32'h5A5A0000 + 32'(i), eRd, eErr);
         access(1, r[i], w[i], a[i], 32'h5A5A0000 + 32'(i), gRd, gErr, lat, ok);
         checks++;
         if (gErr !== eErr || gRd !== eRd || lat != 2 || !ok) begin
            failures++;
            $display("FAIL fault_case%0d addr=%h rd=%b wr=%b: err=%b rdata=%h lat=%0d proto=%b, required err=%b rdata=%h lat=2",
                     i, a[i], r[i], w[i], gErr, gRd, lat, ok, eErr, eRd);
         end
      end
      modelAccess(1, 1'b1, 1'b0, 32'h0, 32'h0, eRd, eErr);
      access(1, 1'b1, 1'b0, 32'h0, 32'h0, gRd, gErr, lat, ok);
      checks++;
      if (gRd !== eRd || gErr !== 1'b0) begin
         failures++;
         $display("FAIL word0_after_both: rdata=%h err=%b, required rdata=%h err=0", gRd, gErr, eRd);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] eRd;
      bit eErr, expPulse;
      @(negedge clk);
      memRead[0] = 1'b1; memWrite[0] = 1'b0; addr[0] = 32'h44; wdata[0] = '0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         expPulse = (i % 2 == 0);
         if (expPulse) modelAccess(0, 1'b1, 1'b0, 32'h44, 32'h0, eRd, eErr);
         checks++;
         if (ready[0] !== expPulse || busy[0] !== expPulse || (expPulse && rdata[0] !== eRd)) begin
            failures++;
            $display("FAIL back_to_back cycle%0d: ready=%b busy=%b rdata=%h, required ready=%b busy=%b rdata=%h",
                     i, ready[0], busy[0], rdata[0], expPulse, expPulse, eRd);
         end
      end
      memRead[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
         failures++;
         $display("FAIL back_to_back_release: ready=%b busy=%b, required 0 0", ready[0], busy[0]);
      end
   endtask

   task automatic test_random;
      logic [31:0] gRd, eRd, a, wd;
      bit gErr, eErr, ok, rd, wr;
      int lat, k;
      for (int d = 0; d < 3; d++) begin
         for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 9);
            if (k == 0)      a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (k == 1) a = 32'($urandom_range(DEPTH, 4000) * 4);
            else             a = 32'($urandom_range(0, DEPTH - 1) * 4);
            k  = $urandom_range(0, 9);
            rd = (k == 0) || (k >= 5);
            wr = (k <= 4);
            wd = $urandom;
            modelAccess(d, rd, wr, a, wd, eRd, eErr);
            access(d, rd, wr, a, wd, gRd, gErr, lat, ok);
            checks++;
            if (gRd !== eRd || gErr !== eErr || lat != int'(wsOf[d]) || !ok) begin
               failures++;
               $display("FAIL random dut%0d #%0d addr=%h rd=%b wr=%b: rdata=%h err=%b lat=%0d proto=%b, required rdata=%h err=%b lat=%0d",
                        d, n, a, rd, wr, gRd, gErr, lat, ok, eRd, eErr, wsOf[d]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_wait;
      logic [31:0] gRd, eRd;
      bit gErr, eErr, ok, sawReady;
      int lat;
      @(negedge clk);
      memWrite[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h0000DEAD;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rdata[1], ready[1], busy[1], err[1]} !== 35'd0) begin
         failures++;
         $display("FAIL reset_mid_wait_outputs: rdata=%h ready=%b busy=%b err=%b, required all 0",
                  rdata[1], ready[1], busy[1], err[1]);
      end
      memWrite[1] = 1'b0;
      sawReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 2) rst_n = 1'b1;
         if (ready[1] !== 1'b0) sawReady = 1'b1;
      end
      checks++;
      if (sawReady) begin
         failures++;
         $display("FAIL reset_mid_wait_no_ready: ready pulse seen, required none");
      end
      for (int d = 0; d < 3; d++) lastRd[d] = '0;
      modelAccess(1, 1'b1, 1'b0, 32'h20, 32'h0, eRd, eErr);
      access(1, 1'b1, 1'b0, 32'h20, 32'h0, gRd, gErr, lat, ok);
      checks++;
      if (gRd !== eRd || gErr !== 1'b0 || lat != 2) begin
         failures++;
         $display("FAIL reset_mid_wait_no_commit: rdata=%h err=%b lat=%0d, required rdata=%h err=0 lat=2",
                  gRd, gErr, lat, eRd);
      end
   endtask

   initial begin
      test_reset();
      test_preload();
      test_store_load();
      test_faults();
      test_back_to_back();
      test_random();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
